// File: rtl/esp32_xfer_pkg.sv
// Shared types and byte-lane helpers for the ESP32 XFER memory bridge.
package esp32_xfer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW
  } state_t;

  // One 32-bit word staged for a memory write.
  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        v;
  } wbuf_t;

  // Replace one little-endian byte lane of a word.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

  // Pull one little-endian byte lane out of a word.
  function automatic logic [7:0] lane_extract(input logic [31:0] word,
                                              input logic [1:0]  lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/esp32_wc_buf.sv
// Write-combine buffer: one open word (wb), one word queued for the memory
// port (fl), byte merging and the idle-flush timeout.
// The word being written to memory always sits in fl, so wb can keep
// accepting bytes while a flush is outstanding.
module esp32_wc_buf
  import esp32_xfer_pkg::*;
#(
  parameter int FLUSH_TO_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [23:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        promote,
  input  logic        fl_clr,
  output wbuf_t       wb,
  output wbuf_t       fl,
  output logic        wr_accept,
  output logic        overrun,
  output logic        flush_want
);

  localparam int CW = $clog2(FLUSH_TO_CYC + 1);

  logic [CW-1:0] to_cnt;
  logic [21:0]   wr_word;
  logic [1:0]    wr_lane;
  logic          wb_live;
  logic          fl_free;
  logic          same_word;
  logic          need_move;

  assign wr_word = wr_addr[23:2];
  assign wr_lane = wr_addr[1:0];
  // A buffer being promoted this cycle is already on its way to fl.
  assign wb_live = wb.v && !promote;
  // fl can take a new word in the same cycle its previous word is acked.
  assign fl_free   = !fl.v || fl_clr;
  assign same_word = wb_live && (wb.addr == wr_word);
  assign need_move = wr_en && wb_live && !same_word;
  assign overrun   = need_move && !fl_free;
  assign wr_accept = wr_en && !overrun;
  assign flush_want = wb.v && ((wb.be == 4'hF) || (to_cnt >= CW'(FLUSH_TO_CYC)));

  // Buffer and flush-register update: clear, promote, then apply the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb <= '0;
      fl <= '0;
    end else begin
      if (fl_clr) fl.v <= 1'b0;
      if (promote) begin
        fl   <= wb;
        wb.v <= 1'b0;
      end
      if (wr_accept) begin
        if (same_word) begin
          wb.data <= lane_insert(wb.data, wr_lane, wr_data);
          wb.be   <= wb.be | lane_onehot(wr_lane);
        end else begin
          if (wb_live) fl <= wb;
          wb.addr <= wr_word;
          wb.data <= lane_insert(32'h0, wr_lane, wr_data);
          wb.be   <= lane_onehot(wr_lane);
          wb.v    <= 1'b1;
        end
      end
    end
  end

  // Idle counter: restarts on any write attempt, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (wr_en || !wb.v || promote) begin
      to_cnt <= '0;
    end else if (to_cnt != CW'(FLUSH_TO_CYC)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/esp32_xfer_mem_bridge.sv
// Bridges byte-wide XFER writes/reads onto a 32-bit word memory port with
// a write-combine buffer and a one-word read cache.
module esp32_xfer_mem_bridge
  import esp32_xfer_pkg::*;
#(
  parameter logic [2:0] SPACE_ID     = 3'd0,
  parameter int         FLUSH_TO_CYC = 64,
  parameter logic [7:0] RD_DUMMY     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wr_en,
  input  logic [2:0]  mem_space,
  input  logic [23:0] mem_wr_addr,
  input  logic [7:0]  mem_wr_data,
  input  logic        mem_rd_req,
  input  logic [2:0]  mem_rd_space,
  input  logic [23:0] mem_rd_addr,
  output logic        mem_rd_valid,
  output logic [7:0]  mem_rd_data,
  output logic        ram_req,
  output logic        ram_we,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic        ram_ack,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata,
  output logic        busy,
  output logic        err_overrun,
  input  logic        err_clr
);

  state_t      state;
  wbuf_t       wb;
  wbuf_t       fl;
  logic        wr_own;
  logic        wr_accept;
  logic        wc_overrun;
  logic        flush_want;
  logic        promote;
  logic        fl_clr;
  logic        fill;
  logic [21:0] wr_word;
  logic [21:0] rd_word;
  logic        rd_own;
  logic        rd_pend_hit;
  logic        rd_hit;
  logic        rd_drop;

  logic        rc_v;
  logic [21:0] rc_addr;
  logic [31:0] rc_data;
  logic        rp_v;
  logic [23:0] rp_addr;

  logic [31:0] rc_data_next;
  logic [21:0] rc_base_addr;
  logic        rc_base_v;

  assign wr_own  = mem_wr_en && (mem_space == SPACE_ID);
  assign wr_word = mem_wr_addr[23:2];
  assign rd_own  = (mem_rd_space == SPACE_ID);
  assign rd_word = mem_rd_addr[23:2];

  assign promote = (state == S_IDLE) && !fl.v && wb.v && (rp_v || flush_want);
  assign fl_clr  = (state == S_WR) && ram_ack;
  assign fill    = (state == S_RDW) && ram_rvalid;

  // Any write not yet in memory for this word (including this cycle's) forces a miss.
  assign rd_pend_hit = (wb.v && (wb.addr == rd_word)) ||
                       (fl.v && (fl.addr == rd_word)) ||
                       (wr_accept && (wr_word == rd_word));
  assign rd_hit  = rc_v && (rc_addr == rd_word) && !rd_pend_hit;
  assign rd_drop = mem_rd_req && rp_v;

  assign busy = (state != S_IDLE) || wb.v || fl.v;

  esp32_wc_buf #(
    .FLUSH_TO_CYC(FLUSH_TO_CYC)
  ) u_wc_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_own),
    .wr_addr   (mem_wr_addr),
    .wr_data   (mem_wr_data),
    .promote   (promote),
    .fl_clr    (fl_clr),
    .wb        (wb),
    .fl        (fl),
    .wr_accept (wr_accept),
    .overrun   (wc_overrun),
    .flush_want(flush_want)
  );

  // Next cache word: fresh fill data (if any) with this cycle's write patched in.
  always_comb begin
    rc_base_addr = fill ? rp_addr[23:2] : rc_addr;
    rc_base_v    = rc_v || fill;
    rc_data_next = fill ? ram_rdata : rc_data;
    if (wr_accept && rc_base_v && (rc_base_addr == wr_word)) begin
      rc_data_next = lane_insert(rc_data_next, mem_wr_addr[1:0], mem_wr_data);
    end
  end

  // Read cache registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_v    <= 1'b0;
      rc_addr <= '0;
      rc_data <= '0;
    end else begin
      rc_v    <= rc_base_v;
      rc_addr <= rc_base_addr;
      rc_data <= rc_data_next;
    end
  end

  // Memory-port FSM plus read request intake; all port outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_be       <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= 8'hFF;
      rp_v         <= 1'b0;
      rp_addr      <= '0;
    end else begin
      mem_rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fl.v) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= fl.addr;
            ram_wdata <= fl.data;
            ram_be    <= fl.be;
            state     <= S_WR;
          end else if (promote) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= wb.addr;
            ram_wdata <= wb.data;
            ram_be    <= wb.be;
            state     <= S_WR;
          end else if (rp_v) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= rp_addr[23:2];
            ram_be   <= 4'hF;
            state    <= S_RD;
          end
        end
        S_WR: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_RD: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= S_RDW;
          end
        end
        S_RDW: begin
          if (ram_rvalid) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= lane_extract(ram_rdata, rp_addr[1:0]);
            rp_v         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (mem_rd_req && !rp_v) begin
        if (!rd_own) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= RD_DUMMY;
        end else if (rd_hit) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= lane_extract(rc_data, mem_rd_addr[1:0]);
        end else begin
          rp_v    <= 1'b1;
          rp_addr <= mem_rd_addr;
        end
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (wc_overrun || rd_drop) begin
      err_overrun <= 1'b1;
    end else if (err_clr) begin
      err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_esp32_xfer_mem_bridge.sv
// Directed bench for esp32_xfer_mem_bridge with a small RAM responder
// (ack when enabled, 3-cycle read latency after ack).
module tb_esp32_xfer_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wr_en;
  logic [2:0]  mem_space;
  logic [23:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_rd_req;
  logic [2:0]  mem_rd_space;
  logic [23:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        ram_req;
  logic        ram_we;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;
  logic        busy;
  logic        err_overrun;
  logic        err_clr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        ack_en;
  int          rd_cnt;
  logic [31:0] rd_word;
  logic [31:0] mem_model [0:255];
  int          n_wr;
  int          n_rd;
  logic [21:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [3:0]  last_wr_be;
  int          last_wr_cyc;
  int          last_rvalid_cyc;
  logic        last_ev_we;
  logic        prev_ev_we;

  esp32_xfer_mem_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_wr_en   (mem_wr_en),
    .mem_space   (mem_space),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_space(mem_rd_space),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_be      (ram_be),
    .ram_ack     (ram_ack),
    .ram_rvalid  (ram_rvalid),
    .ram_rdata   (ram_rdata),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder, driven on the falling edge.
  always @(negedge clk) begin
    logic [31:0] w;
    ram_ack    = 1'b0;
    ram_rvalid = 1'b0;
    if (!rst_n) rd_cnt = 0;
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        ram_rvalid      = 1'b1;
        ram_rdata       = rd_word;
        last_rvalid_cyc = cyc;
      end
    end
    if (rst_n && ram_req && ack_en) begin
      ram_ack    = 1'b1;
      prev_ev_we = last_ev_we;
      last_ev_we = ram_we;
      if (ram_we) begin
        n_wr         = n_wr + 1;
        last_wr_addr = ram_addr;
        last_wr_data = ram_wdata;
        last_wr_be   = ram_be;
        last_wr_cyc  = cyc;
        w = mem_model[ram_addr[7:0]];
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
        mem_model[ram_addr[7:0]] = w;
      end else begin
        n_rd    = n_rd + 1;
        rd_cnt  = 3;
        rd_word = mem_model[ram_addr[7:0]];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [2:0] sp, input logic [23:0] a, input logic [7:0] d);
    mem_wr_en   = 1'b1;
    mem_space   = sp;
    mem_wr_addr = a;
    mem_wr_data = d;
    tick();
    mem_wr_en = 1'b0;
  endtask

  task automatic rd_byte(input logic [2:0] sp, input logic [23:0] a, input bit with_wr,
                         input logic [7:0] wd, output logic [7:0] d, output int lat,
                         output int vcyc);
    int c0;
    c0           = cyc;
    mem_rd_req   = 1'b1;
    mem_rd_space = sp;
    mem_rd_addr  = a;
    if (with_wr) begin
      mem_wr_en   = 1'b1;
      mem_space   = sp;
      mem_wr_addr = a;
      mem_wr_data = wd;
    end
    tick();
    mem_rd_req = 1'b0;
    mem_wr_en  = 1'b0;
    lat  = -1;
    vcyc = -1;
    d    = 8'h00;
    for (int i = 0; i < 100; i++) begin
      if (mem_rd_valid) begin
        lat  = cyc - c0;
        vcyc = cyc;
        d    = mem_rd_data;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy && !ram_req) break;
      tick();
    end
    checks++;
    if (i == 200) begin
      failures++;
      $display("FAIL %s_idle: busy=%b ram_req=%b after 200 cycles, required idle", name, busy, ram_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL rst_ram_req got=%b exp=0", ram_req); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++; if (ram_addr !== 22'h0) begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_wdata !== 32'h0) begin failures++; $display("FAIL rst_ram_wdata got=%h exp=0", ram_wdata); end
    checks++; if (ram_be !== 4'h0) begin failures++; $display("FAIL rst_ram_be got=%h exp=0", ram_be); end
    checks++; if (mem_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", mem_rd_valid); end
    checks++; if (mem_rd_data !== 8'hFF) begin failures++; $display("FAIL rst_rd_data got=%h exp=ff", mem_rd_data); end
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL post_rst_idle busy=%b ram_req=%b exp 0/0", busy, ram_req); end
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    int n0;
    n0 = n_wr;
    wr_byte(3'd0, 24'h000100, 8'h11);
    wr_byte(3'd0, 24'h000101, 8'h22);
    wr_byte(3'd0, 24'h000102, 8'h33);
    wr_byte(3'd0, 24'h000103, 8'h44);
    wait_idle("full_word");
    for (int i = 0; i < 10; i++) tick();
    checks++; if (n_wr - n0 !== 1) begin failures++; $display("FAIL full_count got=%0d exp=1", n_wr - n0); end
    checks++; if (last_wr_addr !== 22'h40) begin failures++; $display("FAIL full_addr got=%h exp=40", last_wr_addr); end
    checks++; if (last_wr_data !== 32'h44332211) begin failures++; $display("FAIL full_wdata got=%h exp=44332211", last_wr_data); end
    checks++; if (last_wr_be !== 4'hF) begin failures++; $display("FAIL full_be got=%h exp=f", last_wr_be); end
    $display("test_full_word: ram writes=%0d addr=%h wdata=%h be=%h", n_wr - n0, last_wr_addr, last_wr_data, last_wr_be);
  endtask

  task automatic test_timeout();
    int n0;
    int c0;
    n0 = n_wr;
    c0 = cyc;
    wr_byte(3'd0, 24'h000205, 8'hAB);
    wait_idle("timeout");
    checks++; if (n_wr - n0 !== 1) begin failures++; $display("FAIL to_count got=%0d exp=1", n_wr - n0); end
    checks++; if (last_wr_addr !== 22'h81) begin failures++; $display("FAIL to_addr got=%h exp=81", last_wr_addr); end
    checks++; if (last_wr_data[15:8] !== 8'hAB) begin failures++; $display("FAIL to_wdata got=%h exp=ab", last_wr_data[15:8]); end
    checks++; if (last_wr_be !== 4'b0010) begin failures++; $display("FAIL to_be got=%b exp=0010", last_wr_be); end
    checks++;
    if ((last_wr_cyc - c0) < 64 || (last_wr_cyc - c0) > 68) begin
      failures++;
      $display("FAIL to_delay got=%0d exp=64..68 cycles", last_wr_cyc - c0);
    end
    $display("test_timeout: write after %0d cycles addr=%h be=%b", last_wr_cyc - c0, last_wr_addr, last_wr_be);
  endtask

  task automatic test_read_cache();
    int n0;
    int lat;
    int vcyc;
    logic [7:0] d;
    n0 = n_rd;
    rd_byte(3'd0, 24'h000040, 1'b0, 8'h00, d, lat, vcyc);
    checks++; if (d !== 8'hEF) begin failures++; $display("FAIL rd1_data got=%h exp=ef", d); end
    checks++; if (vcyc !== last_rvalid_cyc + 1) begin failures++; $display("FAIL rd1_timing got_cyc=%0d exp_cyc=%0d", vcyc, last_rvalid_cyc + 1); end
    $display("test_read_cache: read 0x40 data=%h lat=%0d", d, lat);
    rd_byte(3'd0, 24'h000041, 1'b0, 8'h00, d, lat, vcyc);
    checks++; if (d !== 8'hBE) begin failures++; $display("FAIL rd2_data got=%h exp=be", d); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL rd2_lat got=%0d exp=1", lat); end
    checks++; if (n_rd - n0 !== 1) begin failures++; $display("FAIL rd_count got=%0d exp=1", n_rd - n0); end
    $display("test_read_cache: read 0x41 data=%h lat=%0d ram reads=%0d", d, lat, n_rd - n0);
  endtask

  task automatic test_write_then_read();
    int nw0;
    int nr0;
    int lat;
    int vcyc;
    logic [7:0] d;
    nw0 = n_wr;
    nr0 = n_rd;
    wr_byte(3'd0, 24'h000042, 8'h5A);
    rd_byte(3'd0, 24'h000042, 1'b0, 8'h00, d, lat, vcyc);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL wr_rd_data got=%h exp=5a", d); end
    checks++; if (n_wr - nw0 !== 1 || last_wr_be !== 4'b0100) begin failures++; $display("FAIL wr_rd_write count=%0d be=%b exp 1/0100", n_wr - nw0, last_wr_be); end
    checks++; if (n_rd - nr0 !== 1) begin failures++; $display("FAIL wr_rd_reads got=%0d exp=1", n_rd - nr0); end
    checks++; if (prev_ev_we !== 1'b1 || last_ev_we !== 1'b0) begin failures++; $display("FAIL wr_rd_order got prev_we=%b last_we=%b exp 1/0", prev_ev_we, last_ev_we); end
    $display("test_write_then_read: data=%h", d);
    rd_byte(3'd0, 24'h000043, 1'b1, 8'h77, d, lat, vcyc);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL simul_wr_rd got=%h exp=77", d); end
    $display("test_write_then_read: simultaneous write/read data=%h", d);
    wait_idle("wr_rd");
  endtask

  task automatic test_foreign();
    int nt0;
    int lat;
    int vcyc;
    logic [7:0] d;
    nt0 = n_wr + n_rd;
    rd_byte(3'd3, 24'h000040, 1'b0, 8'h00, d, lat, vcyc);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL foreign_rd_data got=%h exp=ff", d); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL foreign_rd_lat got=%0d exp=1", lat); end
    wr_byte(3'd3, 24'h000010, 8'h99);
    for (int i = 0; i < 80; i++) tick();
    checks++; if (n_wr + n_rd !== nt0) begin failures++; $display("FAIL foreign_traffic got=%0d exp=%0d", n_wr + n_rd, nt0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL foreign_busy got=%b exp=0", busy); end
    $display("test_foreign: rd data=%h lat=%0d ram transactions=%0d", d, lat, n_wr + n_rd - nt0);
  endtask

  task automatic test_overrun();
    ack_en = 1'b0;
    wr_byte(3'd0, 24'h000300, 8'h01);
    wr_byte(3'd0, 24'h000400, 8'h02);
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", err_overrun); end
    wr_byte(3'd0, 24'h000500, 8'h03);
    checks++; if (err_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", err_overrun); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", err_overrun); end
    err_clr = 1'b1;
    wr_byte(3'd0, 24'h000600, 8'h04);
    err_clr = 1'b0;
    checks++; if (err_overrun !== 1'b1) begin failures++; $display("FAIL ovr_wins got=%b exp=1", err_overrun); end
    checks++; if (ram_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ovr_hold ram_req=%b busy=%b exp 1/1", ram_req, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%b exp=0", ram_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    tick();
    rst_n  = 1'b1;
    ack_en = 1'b1;
    tick();
    tick();
    checks++; if (ram_req !== 1'b0 || err_overrun !== 1'b0) begin failures++; $display("FAIL post_rst ram_req=%b err=%b exp 0/0", ram_req, err_overrun); end
    $display("test_overrun done");
  endtask

  initial begin
    rst_n        = 1'b0;
    mem_wr_en    = 1'b0;
    mem_space    = 3'd0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_rd_req   = 1'b0;
    mem_rd_space = 3'd0;
    mem_rd_addr  = '0;
    err_clr      = 1'b0;
    ram_ack      = 1'b0;
    ram_rvalid   = 1'b0;
    ram_rdata    = '0;
    ack_en       = 1'b1;
    rd_cnt       = 0;
    rd_word      = '0;
    n_wr         = 0;
    n_rd         = 0;
    last_wr_addr = '0;
    last_wr_data = '0;
    last_wr_be   = '0;
    last_wr_cyc  = 0;
    last_rvalid_cyc = 0;
    last_ev_we   = 1'b0;
    prev_ev_we   = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    mem_model[8'h10] = 32'hDEADBEEF;

    test_reset();
    test_full_word();
    test_timeout();
    test_read_cache();
    test_write_then_read();
    test_foreign();
    test_overrun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
